mm_job_sequencer: RTL and testbench

- Controller that sequences one NxN systolic matrix_multiplier engine through repeated jobs.
- Accepts N operand beats per job over a valid/ready stream: column k of A and row k of B per beat.
- Drives the engine's synchronous active-high reset, valid and operand inputs, and pads with zero beats until the engine completes.
- Captures the N*N result into a one-deep output buffer released by a valid/ready handshake, so the next job overlaps result draining.

---
 rtl/mm_job_sequencer.sv | 129 ++++++++++++
 tb/tb_mm_job_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_job_sequencer.sv
// Job sequencer for an NxN systolic matrix multiplier: streams N operand beats in,
// pads the engine with zero beats until it finishes, and buffers one result for draining.
`timescale 1ns/1ps
module mm_job_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int N            = 4,
    parameter int C_DATA_WIDTH = 2*DATA_WIDTH + $clog2(N),
    parameter int TIMEOUT      = 2*N
) (
    input  logic                                    clk_i,
    input  logic                                    reset_ni,
    input  logic                                    abort_i,
    input  logic                                    in_valid_i,
    output logic                                    in_ready_o,
    input  logic [N-1:0][DATA_WIDTH-1:0]            in_a_i,
    input  logic [N-1:0][DATA_WIDTH-1:0]            in_b_i,
    output logic                                    out_valid_o,
    input  logic                                    out_ready_i,
    output logic [N*N-1:0][C_DATA_WIDTH-1:0]        out_c_o,
    output logic                                    mm_reset_o,
    output logic                                    mm_valid_o,
    output logic [N-1:0][DATA_WIDTH-1:0]            mm_a_o,
    output logic [N-1:0][DATA_WIDTH-1:0]            mm_b_o,
    input  logic                                    mm_valid_i,
    input  logic [N*N-1:0][C_DATA_WIDTH-1:0]        mm_c_i,
    output logic                                    busy_o,
    output logic [15:0]                             job_count_o,
    output logic                                    err_o
);

    typedef enum logic [1:0] {CLEAR, LOAD, FLUSH} state_t;

    localparam int FLUSH_VALID = 2*N - 2;
    localparam int FLUSH_LIMIT = 2*N - 2 + TIMEOUT;
    localparam int BW          = $clog2(N + 1);
    localparam int FW          = $clog2(FLUSH_LIMIT + 1);

    state_t        state;
    logic [BW-1:0] beat_cnt;
    logic [FW-1:0] flush_cnt;
    logic          accept;
    logic          buf_free;
    logic          capture;

    assign buf_free = !out_valid_o || out_ready_i;
    assign accept   = (state == LOAD) && in_valid_i && !abort_i;
    assign capture  = (state == FLUSH) && !abort_i && mm_valid_i && buf_free;

    assign in_ready_o = (state == LOAD) && !abort_i;
    assign busy_o     = (state != LOAD) || (beat_cnt != '0);

    always_comb begin
        mm_valid_o = 1'b0;
        mm_a_o     = '0;
        mm_b_o     = '0;
        if (state == LOAD) begin
            mm_valid_o = in_valid_i && !abort_i;
            mm_a_o     = in_a_i;
            mm_b_o     = in_b_i;
        end else if (state == FLUSH) begin
            // Once the engine reports done it must not be clocked further, or it would lose the result.
            mm_valid_o = (flush_cnt < FW'(FLUSH_VALID)) && !mm_valid_i && !abort_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state       <= CLEAR;
            mm_reset_o  <= 1'b1;
            beat_cnt    <= '0;
            flush_cnt   <= '0;
            job_count_o <= '0;
            err_o       <= 1'b0;
        end else begin
            mm_reset_o <= 1'b0;
            unique case (state)
                CLEAR: begin
                    state     <= LOAD;
                    beat_cnt  <= '0;
                    flush_cnt <= '0;
                end
                LOAD: begin
                    if (abort_i) begin
                        state      <= CLEAR;
                        mm_reset_o <= 1'b1;
                        beat_cnt   <= '0;
                    end else if (accept) begin
                        if (beat_cnt == BW'(N - 1)) begin
                            state     <= FLUSH;
                            beat_cnt  <= '0;
                            flush_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (abort_i || capture) begin
                        state      <= CLEAR;
                        mm_reset_o <= 1'b1;
                        flush_cnt  <= '0;
                        if (capture) job_count_o <= job_count_o + 16'd1;
                    end else begin
                        if (flush_cnt != FW'(FLUSH_LIMIT)) flush_cnt <= flush_cnt + 1'b1;
                        // Flag rises together with flush_cnt reaching the limit.
                        if ((flush_cnt >= FW'(FLUSH_LIMIT - 1)) && !mm_valid_i) err_o <= 1'b1;
                    end
                end
                default: begin
                    state      <= CLEAR;
                    mm_reset_o <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            out_valid_o <= 1'b0;
            out_c_o     <= '0;
        end else if (capture) begin
            out_valid_o <= 1'b1;
            out_c_o     <= mm_c_i;
        end else if (out_valid_o && out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mm_job_sequencer.sv
// Directed bench for mm_job_sequencer with a behavioural N=4 matrix engine attached.
`timescale 1ns/1ps
module tb_mm_job_sequencer;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int CW = 2*DW + $clog2(N);

    logic                      clk_i = 1'b0;
    logic                      reset_ni;
    logic                      abort_i;
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [N-1:0][DW-1:0]      in_a_i, in_b_i;
    logic                      out_valid_o;
    logic                      out_ready_i;
    logic [N*N-1:0][CW-1:0]    out_c_o;
    logic                      mm_reset_o, mm_valid_o;
    logic [N-1:0][DW-1:0]      mm_a_o, mm_b_o;
    logic                      mm_valid_i;
    logic [N*N-1:0][CW-1:0]    mm_c_i;
    logic                      busy_o;
    logic [15:0]               job_count_o;
    logic                      err_o;

    int n_cmp = 0;
    int n_err = 0;
    int A[N][N], B[N][N], E[N][N];
    bit stuck = 1'b0;

    always #5 clk_i = ~clk_i;

    mm_job_sequencer #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .abort_i(abort_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_a_i(in_a_i), .in_b_i(in_b_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_c_o(out_c_o),
        .mm_reset_o(mm_reset_o), .mm_valid_o(mm_valid_o), .mm_a_o(mm_a_o), .mm_b_o(mm_b_o),
        .mm_valid_i(mm_valid_i), .mm_c_i(mm_c_i),
        .busy_o(busy_o), .job_count_o(job_count_o), .err_o(err_o)
    );

    // Engine model: first N valid cycles carry operands, done after 3N-2 valid cycles, holds until reset.
    logic [N*N-1:0][CW-1:0] eng_acc;
    int                     eng_cnt;
    logic                   eng_valid;

    function automatic logic [N*N-1:0][CW-1:0] mac(input logic [N*N-1:0][CW-1:0] acc,
                                                   input logic [N-1:0][DW-1:0] a,
                                                   input logic [N-1:0][DW-1:0] b);
        logic [N*N-1:0][CW-1:0] r;
        r = acc;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                r[i*N+j] = acc[i*N+j] + CW'(a[i]) * CW'(b[j]);
        return r;
    endfunction

    always @(posedge clk_i) begin
        if (mm_reset_o) begin
            eng_cnt   <= 0;
            eng_valid <= 1'b0;
            eng_acc   <= '0;
        end else if (mm_valid_o && !eng_valid) begin
            if (eng_cnt < N) eng_acc <= mac(eng_acc, mm_a_o, mm_b_o);
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt == 3*N-3) eng_valid <= 1'b1;
        end
    end

    assign mm_valid_i = eng_valid && !stuck;
    assign mm_c_i     = eng_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_mat(input string tag);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("%s_c%0d%0d", tag, i, j), 64'(out_c_o[i*N+j]), 64'(E[i][j]));
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Runs one job starting in the current cycle (cycle 0); done_cyc is the cycle job_count_o changes.
    task automatic run_job(input bit toggle, input bit drain, input int budget,
                           output int done_cyc, output int vcnt, output int rdy_cnt,
                           output int rst_cnt, output int err_cyc, output int unstable);
        int k;
        logic [15:0] jc0;
        logic [N*N-1:0][CW-1:0] snap;
        bit held;
        k = 0; done_cyc = -1; vcnt = 0; rdy_cnt = 0; rst_cnt = 0; err_cyc = -1; unstable = 0;
        jc0  = job_count_o;
        snap = out_c_o;
        held = out_valid_o && !drain;
        for (int cyc = 0; cyc <= budget; cyc++) begin
            out_ready_i = drain && (cyc == 0);
            in_valid_i  = (k < N) && (!toggle || (cyc % 2 == 1));
            for (int i = 0; i < N; i++) begin
                in_a_i[i] = DW'(A[i][(k < N) ? k : 0]);
                in_b_i[i] = DW'(B[(k < N) ? k : 0][i]);
            end
            #1;
            if (job_count_o != jc0) begin
                done_cyc = cyc;
                break;
            end
            if (mm_valid_o) vcnt++;
            if (mm_reset_o) rst_cnt++;
            if (k == N && in_ready_o) rdy_cnt++;
            if (err_o && err_cyc < 0) err_cyc = cyc;
            if (held && out_c_o !== snap) unstable++;
            if (in_valid_i && in_ready_o) k++;
            tick();
        end
        out_ready_i = 1'b0;
        in_valid_i  = 1'b0;
    endtask

    initial begin
        int d, v, r, rc, e, u;
        logic [15:0] jc;
        reset_ni = 1'b0; abort_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        in_a_i = '0; in_b_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_mm_reset", mm_reset_o, 1);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_c_zero", (out_c_o == '0), 1);
        chk("rst_job_count", job_count_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_mm_valid", mm_valid_o, 0);
        chk("rst_busy", busy_o, 1);

        // Job 1: A = identity, B[k][j] = 4k+j+1
        reset_ni = 1'b1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                A[i][j] = (i == j) ? 1 : 0;
                B[i][j] = 4*i + j + 1;
                E[i][j] = 4*i + j + 1;
            end
        run_job(0, 0, 40, d, v, r, rc, e, u);
        chk("j1_latency", d, 12);
        chk("j1_mm_valid_cycles", v, 10);
        chk("j1_reset_pulses", rc, 1);
        chk("j1_out_valid", out_valid_o, 1);
        chk("j1_job_count", job_count_o, 1);
        chk_mat("j1");

        // Job 2: all operands 0xFF, draining job 1 in the first cycle
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                A[i][j] = 255; B[i][j] = 255; E[i][j] = 260100;
            end
        run_job(0, 1, 40, d, v, r, rc, e, u);
        chk("j2_latency", d, 12);
        chk("j2_job_count", job_count_o, 2);
        chk_mat("j2");

        // Job 3: gapped input stream, same matrices as job 1
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                A[i][j] = (i == j) ? 1 : 0;
                B[i][j] = 4*i + j + 1;
                E[i][j] = 4*i + j + 1;
            end
        run_job(1, 1, 40, d, v, r, rc, e, u);
        chk("j3_latency", d, 15);
        chk("j3_mm_valid_cycles", v, 10);
        chk("j3_ready_in_flush", r, 0);
        chk("j3_job_count", job_count_o, 3);
        chk_mat("j3");

        // Job 4 then job 5 with the consumer stalled: job 5 must wait in FLUSH
        run_job(0, 1, 40, d, v, r, rc, e, u);
        chk("j4_job_count", job_count_o, 4);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                A[i][j] = (i == j) ? 2 : 0;
                E[i][j] = 2 * (4*i + j + 1);
            end
        run_job(0, 0, 20, d, v, r, rc, e, u);
        chk("j5_stalled", d, -1);
        chk("j5_mm_valid_cycles", v, 10);
        chk("j5_held_stable", u, 0);
        chk("j5_held_c11", 64'(out_c_o[1*N+1]), 6);
        chk("j5_job_count_held", job_count_o, 4);
        out_ready_i = 1'b1;
        #1;
        chk("j5_stall_mm_valid", mm_valid_o, 0);
        chk("j5_stall_busy", busy_o, 1);
        tick();
        out_ready_i = 1'b0;
        chk("j5_out_valid_kept", out_valid_o, 1);
        chk("j5_job_count", job_count_o, 5);
        chk_mat("j5");

        // Abort after two beats of junk, then a clean job
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        in_a_i = '1; in_b_i = '1;
        tick();
        out_ready_i = 1'b0;
        tick();
        tick();
        abort_i = 1'b1;
        #1;
        chk("ab_in_ready", in_ready_o, 0);
        tick();
        abort_i = 1'b0; in_valid_i = 1'b0;
        chk("ab_mm_reset", mm_reset_o, 1);
        chk("ab_out_valid", out_valid_o, 0);
        jc = job_count_o;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                A[i][j] = (i == j) ? 1 : 0;
                B[i][j] = 16 - (4*i + j);
                E[i][j] = 16 - (4*i + j);
            end
        run_job(0, 0, 40, d, v, r, rc, e, u);
        chk("ab_latency", d, 12);
        chk("ab_reset_pulses", rc, 1);
        chk("ab_job_count", job_count_o, jc + 16'd1);
        chk_mat("ab");

        // Engine never completes: timeout flag, then async reset mid-FLUSH
        stuck = 1'b1;
        run_job(0, 0, 22, d, v, r, rc, e, u);
        chk("to_no_done", d, -1);
        chk("to_err_cycle", e, 19);
        chk("to_err_sticky", err_o, 1);
        chk("to_out_valid_before", out_valid_o, 1);
        #2;
        reset_ni = 1'b0;
        #1;
        chk("ar_mm_reset", mm_reset_o, 1);
        chk("ar_out_valid", out_valid_o, 0);
        chk("ar_out_c_zero", (out_c_o == '0), 1);
        chk("ar_err", err_o, 0);
        chk("ar_job_count", job_count_o, 0);
        chk("ar_busy", busy_o, 1);
        chk("ar_mm_valid", mm_valid_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
